// File: rtl/ser_loader.sv
// Serial training-data loader: shifts WORD_W-bit words in LSB first and writes
// them to memory at {point, word}, words within a point running feat down to 0.
module ser_loader #(
  parameter int WORD_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              S,
  input  logic [3:0]        feat,
  input  logic [11:0]       data_points,
  output logic              WE,
  output logic [15:0]       WADDR,
  output logic [WORD_W-1:0] WDATA,
  output logic              LOAD_DONE,
  output logic              BUSY
);

  // state | meaning
  // LOAD  | shifting serial words in, issuing one WE per completed word
  // DONE  | all points written, S ignored, LOAD_DONE held until reset
  typedef enum logic {LOAD, DONE} state_t;

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

  state_t            state;
  logic [BIT_W-1:0]  bit_cnt;
  logic [3:0]        word_cnt;
  logic [11:0]       point;
  logic [WORD_W-1:0] shift;
  logic [3:0]        word_idx;
  logic              word_end;
  logic              point_end;
  logic              last_point;
  logic [WORD_W-1:0] next_word;

  // Words completed within the point count up, so the reset value is constant
  // while the emitted word index still starts at feat and runs down to 0.
  assign word_idx   = feat - word_cnt;
  assign word_end   = (bit_cnt == LAST_BIT);
  assign point_end  = (word_cnt == feat);
  assign last_point = (point == data_points - 12'd1);
  assign next_word  = {S, shift[WORD_W-1:1]};
  assign BUSY       = (state == LOAD);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= LOAD;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      point     <= '0;
      shift     <= '0;
      WE        <= 1'b0;
      WADDR     <= '0;
      WDATA     <= '0;
      LOAD_DONE <= 1'b0;
    end else begin
      WE <= 1'b0;
      case (state)
        LOAD: begin
          if (data_points == 12'd0) begin
            state     <= DONE;
            LOAD_DONE <= 1'b1;
          end else begin
            shift   <= next_word;
            bit_cnt <= word_end ? '0 : bit_cnt + BIT_W'(1);
            if (word_end) begin
              WE    <= 1'b1;
              WDATA <= next_word;
              WADDR <= {point, word_idx};
              if (point_end) begin
                word_cnt <= '0;
                point    <= point + 12'd1;
                if (last_point) begin
                  state     <= DONE;
                  LOAD_DONE <= 1'b1;
                end
              end else begin
                word_cnt <= word_cnt + 4'd1;
              end
            end
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: doc/ser_loader.md
SER_LOADER -- requirements
Module: ser_loader

Interface
REQ-001 Parameter WORD_W, default 16: bits per serial word.
REQ-002 Port CLK, input, 1: single clock; all state changes on its rising edge.
REQ-003 Port RST, input, 1: reset, asynchronous and active-high.
REQ-004 Port S, input, 1: serial data bit, sampled on each rising CLK edge while in LOAD.
REQ-005 Port feat, input, 4: number of features; words per data point = feat+1, so 1..16 words.
REQ-006 Port data_points, input, 12: number of data points to load, 0..4095.
REQ-007 Port WE, output, 1: one-cycle write strobe to the training-data memory.
REQ-008 Port WADDR, output, 16: write address = {point index[11:0], word index[3:0]}.
REQ-009 Port WDATA, output, WORD_W: assembled word.
REQ-010 Port LOAD_DONE, output, 1: all points loaded; held high until reset.
REQ-011 Port BUSY, output, 1: high while in LOAD.

Function
REQ-012 feat and data_points SHALL be held stable by the driver from RST deassertion until LOAD_DONE; the block SHALL NOT register them.
REQ-013 FSM SHALL have states LOAD and DONE; reset SHALL place it in LOAD.
REQ-014 The first rising edge after RST falls SHALL sample bit 0 of word feat of point 0; there is no start bit.
REQ-015 Words SHALL arrive LSB first; bit counter 0..WORD_W-1 SHALL wrap to 0 after each word.
REQ-016 Within a point, the word index SHALL start at feat and count down to 0; on reaching 0 it SHALL reload feat and increment the point index.
REQ-017 On the edge that samples bit WORD_W-1, the block SHALL register WE=1, WDATA={S, 15 previously shifted bits} and WADDR={point, word}; WE SHALL be 1 for exactly that one cycle.
REQ-018 WE SHALL be 0 in every cycle in which no word completes; WADDR and WDATA SHALL hold their last values.
REQ-019 On the edge completing word 0 of point data_points-1, the block SHALL move to DONE and set LOAD_DONE=1 on the same edge as the final WE.
REQ-020 If data_points=0, the first edge after reset SHALL move to DONE with LOAD_DONE=1 and no WE.
REQ-021 In DONE, S SHALL be ignored; WE SHALL stay 0; BUSY SHALL be 0.
REQ-022 The point counter SHALL be 12 bits wide and SHALL NOT wrap, because REQ-019 terminates loading first.
REQ-023 Total load time SHALL be data_points*(feat+1)*WORD_W cycles from the first sampling edge to LOAD_DONE.

Reset
REQ-024 While RST=1, asynchronously: WE=0, WADDR=0, WDATA=0, LOAD_DONE=0, BUSY=1 (state LOAD), bit counter=0, word index=feat, point index=0, shift register=0.
REQ-025 RST asserted mid-word or mid-point SHALL discard the partial word without issuing a WE; after release, loading SHALL restart at point 0, word feat, bit 0.
REQ-026 RST asserted in DONE SHALL clear LOAD_DONE and restart loading.

Verification
REQ-027 feat=11, data_points=4, 48 words streamed -> 48 WE pulses; first WADDR=0x000B, last WADDR=0x0030; WDATA equals each sent word; LOAD_DONE rises at cycle 768 with the last WE.
REQ-028 Word 0xA5C3 sent LSB first (bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1) -> WDATA=0xA5C3, WE high for exactly one cycle.
REQ-029 data_points=0 -> LOAD_DONE=1 and BUSY=0 after the first edge; WE never asserts.
REQ-030 feat=0, data_points=2 -> WADDR 0x0000 then 0x0010, LOAD_DONE at cycle 32.
REQ-031 RST pulsed after bit 7 of the first word -> no WE, all outputs 0; the re-sent stream yields its first write at WADDR=0x000B with the correct data.
REQ-032 S toggled randomly for 100 cycles after LOAD_DONE -> WE stays 0; WADDR and WDATA unchanged.
